// File: rtl/char_gfx_pkg.sv
// Shared constants and types for the character glyph display path.
// A glyph is a GLYPH_W x GLYPH_H bitmap stored row-major:
// bit index = row*GLYPH_W + col, with row 0 at the top and col 0 at the left.
package char_gfx_pkg;

  localparam int GLYPH_W    = 6;
  localparam int GLYPH_H    = 6;
  localparam int GLYPH_BITS = GLYPH_W * GLYPH_H;
  localparam int RGB_W      = 6;

  localparam int COL_W = $clog2(GLYPH_W);
  localparam int ROW_W = $clog2(GLYPH_H);
  localparam int IDX_W = $clog2(GLYPH_BITS);

  typedef logic [RGB_W-1:0]      rgb_t;
  typedef logic [GLYPH_BITS-1:0] glyph_t;

  // Row-major bit index; the multiply is by a constant, so it folds to adds.
  function automatic logic [IDX_W-1:0] glyph_bit_index(input logic [ROW_W-1:0] row,
                                                       input logic [COL_W-1:0] col);
    return IDX_W'(row) * IDX_W'(GLYPH_W) + IDX_W'(col);
  endfunction

endpackage

// File: rtl/char_glyph_renderer_blink_timer.sv
// Frame counter for the blink effect. Advances once per snapshot and toggles
// blink_phase every BLINK_FRAMES frames. Runs whether or not blink is enabled,
// so enabling blink never restarts the phase.
module blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clock,
  input  logic rst_n,
  input  logic snap,
  output logic blink_phase
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             phase_reg;

  // Count snapshots; wrap at the last frame of a phase and flip the phase.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      phase_reg <= 1'b0;
    end else if (snap) begin
      if (cnt_reg == LAST) begin
        cnt_reg   <= '0;
        phase_reg <= ~phase_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign blink_phase = phase_reg;

endmodule

// File: rtl/char_glyph_renderer.sv
// Renders one scaled glyph box onto the VGA raster. Two-stage pipeline:
// stage 1 maps the raster position to a glyph cell, stage 2 looks the cell up
// in a per-frame shadow copy of the glyph and produces the registered pixel.
module char_glyph_renderer
  import char_gfx_pkg::*;
#(
  parameter int         ORIGIN_X     = 100,
  parameter int         ORIGIN_Y     = 80,
  parameter int         SCALE_LOG2   = 3,
  parameter int         BLINK_FRAMES = 30,
  parameter logic [RGB_W-1:0] FG_RGB = 6'b111111,
  parameter logic [RGB_W-1:0] BG_RGB = 6'b000000
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [9:0]            h_count,
  input  logic [9:0]            v_count,
  input  logic                  video_active,
  input  logic [GLYPH_BITS-1:0] glyph,
  input  logic                  blink_en,
  output logic [RGB_W-1:0]      rgb,
  output logic                  in_box,
  output logic                  frame_tick
);

  localparam logic [9:0] ORG_X = 10'(ORIGIN_X);
  localparam logic [9:0] ORG_Y = 10'(ORIGIN_Y);
  localparam logic [9:0] BOX_W = 10'(GLYPH_W << SCALE_LOG2);
  localparam logic [9:0] BOX_H = 10'(GLYPH_H << SCALE_LOG2);

  // Stage 1 combinational mapping
  logic [9:0] rel_x;
  logic [9:0] rel_y;
  logic       box_hit;
  logic       snap;

  // Stage 1 registers
  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;
  logic             box_hit_reg;
  logic             active_reg;

  // Stage 2 / frame state
  logic [GLYPH_BITS-1:0] shadow_reg;
  logic [RGB_W-1:0]      rgb_reg;
  logic                  in_box_reg;
  logic                  frame_tick_reg;
  logic                  blink_phase;

  logic [IDX_W-1:0] bit_idx;
  logic             bit_sel;
  logic             lit;
  logic [RGB_W-1:0] rgb_next;

  // The >= checks stop positions left of / above the origin from wrapping
  // into the box through the unsigned subtraction.
  assign rel_x   = h_count - ORG_X;
  assign rel_y   = v_count - ORG_Y;
  assign box_hit = (h_count >= ORG_X) && (rel_x < BOX_W) &&
                   (v_count >= ORG_Y) && (rel_y < BOX_H) && video_active;
  assign snap    = (h_count == 10'd0) && (v_count == 10'd0);

  blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink_timer (
    .clock       (clock),
    .rst_n       (rst_n),
    .snap        (snap),
    .blink_phase (blink_phase)
  );

  // Stage 1: register cell coordinates; zeroed outside the box so the
  // stage-2 index always stays inside the glyph.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      col_reg     <= '0;
      row_reg     <= '0;
      box_hit_reg <= 1'b0;
      active_reg  <= 1'b0;
    end else begin
      col_reg     <= box_hit ? rel_x[SCALE_LOG2 +: COL_W] : '0;
      row_reg     <= box_hit ? rel_y[SCALE_LOG2 +: ROW_W] : '0;
      box_hit_reg <= box_hit;
      active_reg  <= video_active;
    end
  end

  // Stage 2 pixel decision: glyph bit, optional blink inversion, blanking.
  always_comb begin
    bit_idx  = glyph_bit_index(row_reg, col_reg);
    bit_sel  = box_hit_reg ? shadow_reg[bit_idx] : 1'b0;
    lit      = bit_sel ^ (blink_en & blink_phase & box_hit_reg);
    rgb_next = '0;
    if (lit) begin
      rgb_next = FG_RGB;
    end else if (active_reg) begin
      rgb_next = BG_RGB;
    end
  end

  // Snapshot the glyph at frame start; stage 2 still reads the old copy on
  // this same edge, so the previous frame's last pixels are unaffected.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      shadow_reg     <= '0;
      frame_tick_reg <= 1'b0;
    end else begin
      if (snap) begin
        shadow_reg <= glyph;
      end
      frame_tick_reg <= snap;
    end
  end

  // Stage 2 output registers.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      rgb_reg    <= '0;
      in_box_reg <= 1'b0;
    end else begin
      rgb_reg    <= rgb_next;
      in_box_reg <= box_hit_reg;
    end
  end

  assign rgb        = rgb_reg;
  assign in_box     = in_box_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_char_glyph_renderer.sv
// Self-checking bench for char_glyph_renderer. Each drive() pushes the
// expected pixel from a small behavioural model into a scoreboard; a monitor
// pops and compares when the 2-cycle pipeline delivers the pixel.
module tb_char_glyph_renderer;

  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic        video_active;
  logic [35:0] glyph;
  logic        blink_en;
  logic [5:0]  rgb;
  logic        in_box;
  logic        frame_tick;

  always #5 clk = ~clk;

  char_glyph_renderer #(
    .BLINK_FRAMES(BF)
  ) dut (
    .clock        (clk),
    .rst_n        (rst_n),
    .h_count      (h_count),
    .v_count      (v_count),
    .video_active (video_active),
    .glyph        (glyph),
    .blink_en     (blink_en),
    .rgb          (rgb),
    .in_box       (in_box),
    .frame_tick   (frame_tick)
  );

  typedef struct {
    logic [5:0] rgb;
    logic       box;
    int         due;
    int         h;
    int         v;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cycle = 0;
  int   tick_count = 0;

  // Reference model state
  logic [35:0] m_shadow;
  int          m_cnt;
  logic        m_phase;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) if (rst_n === 1'b1 && frame_tick === 1'b1) tick_count++;

  // Scoreboard monitor
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cycle) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (e.due != cycle || rgb !== e.rgb || in_box !== e.box) begin
        n_err++;
        $display("FAIL pixel h=%0d v=%0d: got rgb=%h in_box=%b (cycle %0d), expected rgb=%h in_box=%b (cycle %0d)",
                 e.h, e.v, rgb, in_box, cycle, e.rgb, e.box, e.due);
      end
    end
  end

  task automatic model_reset();
    m_shadow = '0;
    m_cnt    = 0;
    m_phase  = 1'b0;
  endtask

  task automatic idle();
    h_count      = 10'd700;
    v_count      = 10'd500;
    video_active = 1'b0;
  endtask

  // Apply one raster position and predict its pixel two clocks later.
  task automatic drive(input int h, input int v, input logic va);
    exp_t e;
    logic hit, b, lit;
    int   col, row;
    h_count      = 10'(h);
    v_count      = 10'(v);
    video_active = va;
    if (h == 0 && v == 0) begin
      m_shadow = glyph;
      if (m_cnt == BF - 1) begin
        m_cnt   = 0;
        m_phase = ~m_phase;
      end else begin
        m_cnt++;
      end
    end
    hit = (h >= 100) && (h < 148) && (v >= 80) && (v < 128) && va;
    b   = 1'b0;
    if (hit) begin
      col = (h - 100) / 8;
      row = (v - 80) / 8;
      b   = m_shadow[row * 6 + col];
    end
    lit   = b ^ (blink_en & m_phase & hit);
    e.rgb = lit ? 6'h3F : 6'h00;
    e.box = hit;
    e.due = cycle + 2;
    e.h   = h;
    e.v   = v;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 8 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d pixels still pending, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic apply_reset(input int n);
    idle();
    rst_n = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    glyph    = '1;
    blink_en = 1'b1;
    rst_n    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      h_count      = 10'(i * 100);
      v_count      = 10'(i * 80);
      video_active = 1'b1;
      @(posedge clk);
      #1;
      n_vec++;
      if (rgb !== 6'h00) begin n_err++; $display("FAIL reset_rgb[%0d]: got %h, expected 00", i, rgb); end
      n_vec++;
      if (in_box !== 1'b0) begin n_err++; $display("FAIL reset_in_box[%0d]: got %b, expected 0", i, in_box); end
      n_vec++;
      if (frame_tick !== 1'b0) begin n_err++; $display("FAIL reset_frame_tick[%0d]: got %b, expected 0", i, frame_tick); end
    end
    idle();
    rst_n    = 1'b1;
    blink_en = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_pixel();
    glyph = 36'h000000001;
    drive(0, 0, 1'b0);
    n_vec++;
    if (frame_tick !== 1'b1) begin n_err++; $display("FAIL single_tick_high: got %b, expected 1", frame_tick); end
    drive(100, 80, 1'b1);
    n_vec++;
    if (frame_tick !== 1'b0) begin n_err++; $display("FAIL single_tick_low: got %b, expected 0", frame_tick); end
    drive(108, 80, 1'b1);
    drain();
  endtask

  task automatic test_box_edges();
    int hx[10];
    int vy[10];
    hx = '{99, 100, 147, 148, 110, 110, 110, 110, 0, 1023};
    vy = '{90, 90, 90, 90, 79, 80, 127, 128, 90, 1023};
    glyph = '1;
    drive(0, 0, 1'b0);
    for (int i = 0; i < 10; i++) drive(hx[i], vy[i], 1'b1);
    drain();
  endtask

  task automatic test_midframe_change();
    int t0;
    t0    = tick_count;
    glyph = 36'h000000001;
    drive(0, 0, 1'b0);
    drive(100, 80, 1'b1);
    glyph = 36'h000000002;
    drive(300, 200, 1'b1);
    n_vec++;
    if (frame_tick !== 1'b0) begin n_err++; $display("FAIL midframe_tick: got %b, expected 0", frame_tick); end
    drive(100, 80, 1'b1);
    drive(108, 80, 1'b1);
    glyph = 36'h800000002;
    drive(147, 127, 1'b1);
    drive(0, 0, 1'b0);
    drive(147, 127, 1'b1);
    drive(108, 80, 1'b1);
    drive(100, 80, 1'b1);
    drain();
    n_vec++;
    if (tick_count - t0 != 2) begin
      n_err++;
      $display("FAIL tick_count: got %0d pulses, expected 2", tick_count - t0);
    end
  endtask

  task automatic test_blink();
    apply_reset(1);
    glyph    = '0;
    blink_en = 1'b1;
    drive(120, 100, 1'b1);
    for (int f = 1; f <= 5; f++) begin
      drive(0, 0, 1'b0);
      drive(120, 100, 1'b1);
    end
    drain();
    blink_en = 1'b0;
  endtask

  task automatic test_blanking();
    glyph = '1;
    drive(0, 0, 1'b0);
    drive(120, 100, 1'b0);
    drive(120, 100, 1'b1);
    drive(20, 20, 1'b1);
    drive(130, 110, 1'b0);
    drain();
  endtask

  task automatic test_reset_midframe();
    glyph = '1;
    drive(0, 0, 1'b0);
    drive(100, 80, 1'b1);
    drain();
    apply_reset(1);
    n_vec++;
    if (rgb !== 6'h00 || in_box !== 1'b0 || frame_tick !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_outputs: got rgb=%h in_box=%b tick=%b, expected 00 0 0", rgb, in_box, frame_tick);
    end
    drive(100, 80, 1'b1);
    drive(0, 0, 1'b0);
    drive(100, 80, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [63:0] r;
    blink_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        r     = {$urandom(), $urandom()};
        glyph = r[35:0];
      end
      if ($urandom_range(0, 39) == 0) drive(0, 0, 1'b0);
      else drive($urandom_range(95, 152), $urandom_range(75, 132), $urandom_range(0, 5) != 0);
    end
    drain();
    blink_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    glyph    = '0;
    blink_en = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    test_reset();
    test_single_pixel();
    test_box_edges();
    test_midframe_change();
    test_blink();
    test_blanking();
    test_reset_midframe();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
